// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: RV32I fetch stage that owns the fetch PC, issues credit-limited imem requests,
// queues returned words for decode and squashes stale fetches on EX redirects. Option: FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH        = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);
    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW  = $clog2(FQ_DEPTH + 1);
    localparam int unsigned AW  = $clog2(FQ_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_TRAP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [31:0]   q_pc_q    [FQ_DEPTH];
    logic [31:0]   q_pc_d    [FQ_DEPTH];
    logic [31:0]   q_instr_q [FQ_DEPTH];
    logic [31:0]   q_instr_d [FQ_DEPTH];
    logic          req_q, req_d;
    logic          vld_q, vld_d;
    logic [31:0]   hpc_q, hpc_d;
    logic [31:0]   hinstr_q, hinstr_d;

    logic [31:0]   redir_tgt;
    logic          redir_bad;
    logic          grant, push, pop, drop_rsp;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_tgt = redir_pc;
    assign redir_bad = (redir_pc[1:0] != 2'b00);
`else
    assign redir_tgt = redir_pc & ~32'h0000_0003;
    assign redir_bad = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: redirects steer between RUN and TRAP
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = (redir_valid && redir_bad) ? S_TRAP : S_RUN;
            S_RUN:   if (redir_valid && redir_bad) state_d = S_TRAP;
            S_TRAP:  if (redir_valid && !redir_bad) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // Datapath next state: credits, drop counter, fetch queue and registered head
    always_comb begin
        grant    = req_q & imem_gnt;
        drop_rsp = imem_rvalid & (drop_q != '0);
        push     = imem_rvalid & (drop_q == '0);
        pop      = vld_q & if_ready;

        out_d     = out_q + OW'(grant) - OW'(imem_rvalid);
        drop_d    = drop_q - OW'(drop_rsp);
        pc_d      = grant ? (pc_q + 32'd4) : pc_q;
        rsp_pc_d  = push ? (rsp_pc_q + 32'd4) : rsp_pc_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        q_pc_d    = q_pc_q;
        q_instr_d = q_instr_q;

        if (push) begin
            q_pc_d[wr_q]    = rsp_pc_q;
            q_instr_d[wr_q] = imem_rdata;
            wr_d            = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        // Everything still in flight after this cycle's updates belongs to the old path
        if (redir_valid) begin
            pc_d     = redir_tgt;
            rsp_pc_d = redir_tgt;
            drop_d   = out_d;
            wr_d     = '0;
            rd_d     = '0;
            cnt_d    = '0;
        end

        vld_d    = (cnt_d != '0);
        hpc_d    = vld_d ? q_pc_d[rd_d] : 32'h0;
        hinstr_d = vld_d ? q_instr_d[rd_d] : NOP;
        req_d    = (state_d == S_RUN)
                && (32'(out_d) < MAX_OUTSTANDING)
                && ((32'(out_d - drop_d) + 32'(cnt_d)) < FQ_DEPTH);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            req_q    <= 1'b0;
            vld_q    <= 1'b0;
            hpc_q    <= 32'h0;
            hinstr_q <= NOP;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            req_q    <= req_d;
            vld_q    <= vld_d;
            hpc_q    <= hpc_d;
            hinstr_q <= hinstr_d;
        end
    end

    // Queue storage needs no reset: entries are only read behind a valid count
    always_ff @(posedge clk) begin
        q_pc_q    <= q_pc_d;
        q_instr_q <= q_instr_d;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault_q, fault_d;
    logic [31:0] fpc_q, fpc_d;

    always_comb begin
        fault_d = fault_q;
        fpc_d   = fpc_q;
        if (redir_valid) begin
            fault_d = redir_bad;
            fpc_d   = redir_bad ? redir_pc : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fault_q <= 1'b0;
            fpc_q   <= 32'h0;
        end else begin
            fault_q <= fault_d;
            fpc_q   <= fpc_d;
        end
    end

    assign fetch_fault = fault_q;
    assign fault_pc    = fpc_q;
`else
    assign fetch_fault = 1'b0;
    assign fault_pc    = 32'h0;
`endif

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign if_valid  = vld_q;
    assign if_pc     = hpc_q;
    assign if_instr  = hinstr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed stimulus with an expected-PC scoreboard popped by a decode-side monitor,
// plus an in-order imem model whose responses can be held back.
module tb_pc_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk         = 1'b0;
    logic        rstn        = 1'b1;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc    = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready    = 1'b0;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb_pc[$];
    logic [31:0] pend[$];
    logic        mem_hold = 1'b0;
    logic [31:0] mon_exp;

    pc_fetch_unit dut (
        .clk         (clk),
        .rstn        (rstn),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_ready    (if_ready),
        .fetch_fault (fetch_fault),
        .fault_pc    (fault_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Memory: record handshakes mid-cycle, answer one per cycle in grant order
    always @(negedge clk) begin
        if (!rstn) pend.delete();
        else if (imem_req && imem_gnt) pend.push_back(imem_addr);
    end

    always @(posedge clk) begin
        #2;
        if (rstn && !mem_hold && pend.size() != 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mk_instr(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // Decode-side monitor: every accepted head must match the next expected PC
    always @(negedge clk) begin
        if (rstn && if_valid && if_ready) begin
            n_checks++;
            if (sb_pc.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got pc %08h expected no pop", if_pc);
            end else begin
                mon_exp = sb_pc.pop_front();
                if (if_pc !== mon_exp || if_instr !== mk_instr(mon_exp)) begin
                    n_fail++;
                    $display("FAIL pop_seq: got pc %08h instr %08h expected pc %08h instr %08h",
                             if_pc, if_instr, mon_exp, mk_instr(mon_exp));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_run(input logic [31:0] base, input int n);
        int cyc;
        for (int i = 0; i < n; i++) sb_pc.push_back(base + 32'(4 * i));
        if_ready = 1'b1;
        cyc = 0;
        while (sb_pc.size() != 0 && cyc < 300) begin
            step();
            cyc++;
        end
        if_ready = 1'b0;
        n_checks++;
        if (sb_pc.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%08h: got %0d words missing expected 0", base, sb_pc.size());
            sb_pc.delete();
        end
    endtask

    task automatic settle();
        repeat (6) step();
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redir_valid = 1'b1;
        redir_pc    = tgt;
        step();
        redir_valid = 1'b0;
    endtask

    initial begin
        #1 rstn = 1'b0;
        step();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, NOP);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_fault_pc", fault_pc, 32'h0);
        imem_gnt = 1'b1;
        step();
        rstn = 1'b1;

        // Streaming from reset
        expect_run(32'h0, 8);
        settle();

        // Decode stall: queue holds FQ_DEPTH words, issue stops
        repeat (10) step();
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_valid", 32'(if_valid), 32'd1);
        check("stall_pc", if_pc, 32'h20);
        check("stall_instr", if_instr, mk_instr(32'h20));
        expect_run(32'h20, 8);
        settle();

        // Two outstanding held in memory, then redirect
        mem_hold = 1'b1;
        expect_run(32'h40, 2);
        repeat (4) step();
        check("outst_req", 32'(imem_req), 32'd0);
        check("outst_addr", imem_addr, 32'h50);
        mem_hold = 1'b0;
        redirect(32'h100);
        check("redir_addr", imem_addr, 32'h100);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_flush", 32'(if_valid), 32'd0);
        expect_run(32'h100, 4);
        settle();

        // Redirect coinciding with a grant and a pop
        sb_pc.push_back(32'h110);
        sb_pc.push_back(32'h114);
        if_ready = 1'b1;
        check("coll_req_full", 32'(imem_req), 32'd0);
        step();
        check("coll_valid", 32'(if_valid), 32'd1);
        check("coll_head", if_pc, 32'h114);
        check("coll_req", 32'(imem_req), 32'd1);
        check("coll_addr", imem_addr, 32'h118);
        redirect(32'h200);
        if_ready = 1'b0;
        check("coll_flush", 32'(if_valid), 32'd0);
        check("coll_new_addr", imem_addr, 32'h200);
        check("coll_sb_empty", 32'(sb_pc.size()), 32'd0);
        expect_run(32'h200, 4);
        settle();

        // Grant withheld: address must stay put until a redirect
        imem_gnt = 1'b0;
        expect_run(32'h210, 2);
        for (int i = 0; i < 5; i++) begin
            step();
            check("nogrant_req", 32'(imem_req), 32'd1);
            check("nogrant_addr", imem_addr, 32'h218);
        end
        redirect(32'h300);
        check("nogrant_redir_addr", imem_addr, 32'h300);
        check("nogrant_redir_req", 32'(imem_req), 32'd1);
        imem_gnt = 1'b1;
        expect_run(32'h300, 3);
        settle();

        // Misaligned redirect
`ifdef FETCH_MISALIGN_TRAP_EN
        redirect(32'h102);
        check("trap_fault", 32'(fetch_fault), 32'd1);
        check("trap_fault_pc", fault_pc, 32'h102);
        check("trap_req", 32'(imem_req), 32'd0);
        check("trap_flush", 32'(if_valid), 32'd0);
        repeat (3) step();
        check("trap_hold_req", 32'(imem_req), 32'd0);
        check("trap_hold_fault", 32'(fetch_fault), 32'd1);
        redirect(32'h200);
        check("trap_exit_fault", 32'(fetch_fault), 32'd0);
        check("trap_exit_req", 32'(imem_req), 32'd1);
        check("trap_exit_addr", imem_addr, 32'h200);
        expect_run(32'h200, 3);
`else
        redirect(32'h102);
        check("align_fault", 32'(fetch_fault), 32'd0);
        check("align_fault_pc", fault_pc, 32'h0);
        check("align_req", 32'(imem_req), 32'd1);
        check("align_addr", imem_addr, 32'h100);
        check("align_flush", 32'(if_valid), 32'd0);
        expect_run(32'h100, 3);
`endif
        settle();

        // PC wraps past 2^32
        redirect(32'hFFFF_FFF8);
        expect_run(32'hFFFF_FFF8, 4);
        settle();

        // Reset mid-operation
        rstn = 1'b0;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_valid", 32'(if_valid), 32'd0);
        check("mid_rst_pc", if_pc, 32'h0);
        check("mid_rst_instr", if_instr, NOP);
        step();
        step();
        rstn = 1'b1;
        expect_run(32'h0, 4);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

endmodule
